// File: rtl/ex_muldiv_ctrl.sv
// Iterative multiply/divide sequencer with HI/LO result registers and pipeline stall.
// Optional macro MULDIV_ZERO_SKIP_EN: MULT/MULTU with a zero operand completes in one cycle.
module ex_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [WIDTH-1:0]   acc_hi_reg;
    logic [WIDTH-1:0]   acc_lo_reg;
    logic               is_div_reg;
    logic               sign_a_reg;
    logic               sign_b_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    // Issue-time decode
    logic               op_signed;
    logic               op_div;
    logic               div_zero;
    logic               mul_zero;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign op_signed = ~op[0];
    assign op_div    = op[1];
    assign div_zero  = op_div && (src_b == '0);
`ifdef MULDIV_ZERO_SKIP_EN
    assign mul_zero  = !op_div && ((src_a == '0) || (src_b == '0));
`else
    assign mul_zero  = 1'b0;
`endif
    assign abs_a = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // Multiply step: accumulator {acc_hi, acc_lo} shifts right, multiplier bits consumed from acc_lo[0]
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_next;
    logic [WIDTH-1:0]   mul_lo_next;

    assign mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};

    // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_hi_next;
    logic [WIDTH-1:0]   div_lo_next;

    assign div_shift   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_ge      = div_shift >= {1'b0, opnd_reg};
    assign div_diff    = div_shift - {1'b0, opnd_reg};
    assign div_hi_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_next = {acc_lo_reg[WIDTH-2:0], div_ge};

    // Sign correction applied on the FIX -> DONE edge
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod_neg = -{acc_hi_reg, acc_lo_reg};

    always_comb begin
        fix_hi = acc_hi_reg;
        fix_lo = acc_lo_reg;
        if (is_div_reg) begin
            if (sign_a_reg ^ sign_b_reg) fix_lo = -acc_lo_reg;
            if (sign_a_reg)              fix_hi = -acc_hi_reg;
        end else if (sign_a_reg ^ sign_b_reg) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic; flush outranks normal advance
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = (div_zero || mul_zero) ? DONE : RUN;
            RUN: begin
                if (flush)                 state_next = IDLE;
                else if (cnt_reg == '0)    state_next = FIX;
            end
            FIX:  state_next = flush ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            opnd_reg   <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            is_div_reg <= 1'b0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hi_we) hi_reg <= wdata;
                    if (lo_we) lo_reg <= wdata;
                    if (start) begin
                        cnt_reg    <= CW'(WIDTH - 1);
                        is_div_reg <= op_div;
                        sign_a_reg <= op_signed && src_a[WIDTH-1];
                        sign_b_reg <= op_signed && src_b[WIDTH-1];
                        acc_hi_reg <= '0;
                        acc_lo_reg <= op_div ? abs_a : abs_b;
                        opnd_reg   <= op_div ? abs_b : abs_a;
                        // Short-circuit results win over a coincident direct write
                        if (div_zero) begin
                            hi_reg <= src_a;
                            lo_reg <= '1;
                        end else if (mul_zero) begin
                            hi_reg <= '0;
                            lo_reg <= '0;
                        end
                    end
                end
                RUN: begin
                    if (!flush) begin
                        cnt_reg    <= cnt_reg - 1'b1;
                        acc_hi_reg <= is_div_reg ? div_hi_next : mul_hi_next;
                        acc_lo_reg <= is_div_reg ? div_lo_next : mul_lo_next;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi_reg <= fix_hi;
                        lo_reg <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
- Sequencer for an iterative, shared multiply/divide resource beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU from ID/EX and runs a 1-bit-per-cycle shift-add multiplier or restoring divider.
- Holds the HI/LO result registers and drives a stall to the ID/EX pipeline register while busy.
- Also services HI/LO direct writes (MTHI/MTLO).

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  issue request, sampled at posedge; accepted only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  input  WIDTH  multiplicand / dividend.
- src_b  input  WIDTH  multiplier / divisor.
- flush  input  1  cancel the in-flight operation.
- hi_we  input  1  direct write of HI (MTHI).
- lo_we  input  1  direct write of LO (MTLO).
- wdata  input  WIDTH  data for hi_we/lo_we.
- busy  output  1  operation in flight; drives pipeline stall.
- done  output  1  one-cycle pulse when HI/LO carry a new result.
- hi  output  WIDTH  HI register (product high half / remainder).
- lo  output  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0; done=0; hi=0; lo=0; iteration counter=0; internal accumulators=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 latches |a| and |b| for signed ops (raw operands for unsigned), sign flags, op and counter=WIDTH-1, then goes to RUN.
  - Special case: DIV/DIVU with src_b=0 goes straight to DONE, loading hi=src_a, lo={WIDTH{1'b1}}.
- RUN: one iteration per cycle.
  - Multiply: add shifted multiplicand if the current multiplier bit is 1, shift 2*WIDTH accumulator.
  - Divide: shift remainder/quotient left, trial-subtract divisor, restore if negative, shift in quotient bit.
  - Leaves RUN after exactly WIDTH cycles (counter reaches 0), going to FIX.
- FIX: one cycle; signed-result correction.
  - MULT: negate the 2*WIDTH product if sign_a^sign_b.
  - DIV: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Unsigned ops pass through unchanged. Goes to DONE.
- DONE: hi/lo are loaded on entry; done=1 for this single cycle; next state is IDLE.
- Latency:
  - Normal operation: done is high in the cycle WIDTH+2 clocks after the start edge (34 clocks for WIDTH=32).
  - Divide-by-zero: done is high in the cycle 1 clock after the start edge.
- busy=1 in RUN, FIX and DONE; 0 in IDLE. busy deasserts combinationally with the return to IDLE, so a back-to-back start can be accepted on the edge that leaves DONE's successor.
- start while busy is ignored; no queuing.
- flush=1 in any non-IDLE state forces IDLE on the next edge, with done=0 and hi/lo unchanged.
  - flush has priority over state advance.
  - flush in IDLE has no effect; start in the same cycle as flush in IDLE is accepted.
- Direct writes:
  - hi_we/lo_we update hi/lo in IDLE only; both may fire in the same cycle.
  - While busy they are ignored; the pipeline stall guarantees no issue.
  - Writes coincident with start in IDLE take effect, then the operation's result overwrites them at DONE.
- Arithmetic wraps modulo 2^WIDTH.
  - MULT -2^31 * -2^31 yields hi=0x40000000, lo=0.
  - DIV -2^31 / -1 yields lo=0x80000000, hi=0 (no trap).

Optional Feature:
- Macro: MULDIV_ZERO_SKIP_EN.
- Defined: MULT/MULTU with src_a=0 or src_b=0 skips RUN/FIX and goes to DONE next cycle with hi=lo=0 (done 1 clock after start).
- Undefined: zero operands take the full WIDTH+2 cycle path with the identical result.

Test Plan:
- Reset mid-RUN (rst pulsed at cycle 10 of a MULT) -> busy=0, done=0, hi=lo=0 immediately, without waiting for a clock.
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> busy for 34 cycles, done pulse once, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 100/7 -> lo=0x0000000E, hi=0x00000002. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV src_a=0x12345678, src_b=0 -> done 1 cycle after start, hi=0x12345678, lo=0xFFFFFFFF.
- MULTU 6*7 with flush asserted at RUN cycle 5 -> IDLE next edge, no done, hi/lo keep the prior MTHI/MTLO values 0xAAAA0000/0x0000BBBB; a new start in the following cycle is accepted.
- start pulsed during RUN, and hi_we while busy -> both ignored, the single original result is delivered; with MULDIV_ZERO_SKIP_EN, MULT 0*9 -> done after 1 cycle, hi=lo=0.
